// File: rtl/jtbubl_pal_sched_if.sv
// CPU-side palette bus between the address decoder and the palette write
// scheduler.
//   pal_cs      - palette chip select from the CPU decoder
//   cpu_rnw     - CPU read/not-write
//   cpu_addr    - palette byte address (bit 0 selects even/odd RAM)
//   cpu_dout    - CPU write data
//   pal_wait    - CPU stall request, high while a write cannot be accepted
//   pal_pending - high while writes are queued but not yet committed
// master: CPU/decoder side. slave: scheduler side.
interface jtbubl_pal_sched_if;
  logic       pal_cs;
  logic       cpu_rnw;
  logic [8:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic       pal_wait;
  logic       pal_pending;

  modport master (
    output pal_cs, cpu_rnw, cpu_addr, cpu_dout,
    input  pal_wait, pal_pending
  );

  modport slave (
    input  pal_cs, cpu_rnw, cpu_addr, cpu_dout,
    output pal_wait, pal_pending
  );
endinterface

// File: rtl/jtbubl_pal_sched.sv
// Palette write scheduler. CPU palette writes are queued in a small FIFO and
// only written into the palette RAM during blanking, so colours never change
// mid-line. With JTBUBL_PALCLR_EN defined, the whole 512-byte palette is swept
// to zero after reset before any queued write is committed.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   LHBL, LVBL      - horizontal / vertical blank, active low
//   cpu             - CPU palette bus (slave modport of jtbubl_pal_sched_if)
//   clr_busy        - high during the post-reset clear sweep
//   ram_we          - palette RAM write strobe, one clk per byte
//   ram_addr        - palette RAM byte address
//   ram_din         - palette RAM write data
// Parameter AW: FIFO address width, depth = 2**AW.
module jtbubl_pal_sched #(
  parameter int AW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  LHBL,
  input  logic                  LVBL,
  jtbubl_pal_sched_if.slave     cpu,
  output logic                  clr_busy,
  output logic                  ram_we,
  output logic [8:0]            ram_addr,
  output logic [7:0]            ram_din
);

  localparam int unsigned DEPTH = 2**AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_CLEAR} state_t;

`ifdef JTBUBL_PALCLR_EN
  localparam state_t RST_STATE = ST_CLEAR;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t state, state_nxt;

  logic        wr, wr_l, req, blank;
  logic        pop, push;
  logic [16:0] push_data;
  logic [16:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_nxt;
  logic        full, empty, full_nxt;
  logic        pend, pend_nxt;
  logic [16:0] pend_data;

  logic        ram_we_nxt;
  logic [8:0]  ram_addr_nxt;
  logic [7:0]  ram_din_nxt;

`ifdef JTBUBL_PALCLR_EN
  logic [8:0]  clr_addr;
  logic        clr_busy_nxt;
`endif

  assign wr    = cpu.pal_cs & ~cpu.cpu_rnw;
  assign req   = wr & ~wr_l;
  assign blank = ~LHBL | ~LVBL;
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  // --- FIFO and overflow pending register ---------------------------------
  // The pending entry only ever exists while the FIFO is full, so it can be
  // pushed in the slot freed by a pop without changing the count.
  assign push      = (req & ~full) | (pend & pop);
  assign push_data = pend ? pend_data : {cpu.cpu_addr, cpu.cpu_dout};
  assign pend_nxt  = pend ? ~pop : (req & full);

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + 1'b1;
    else if (pop && !push)
      cnt_nxt = cnt - 1'b1;
  end

  assign full_nxt = (cnt_nxt == FULL_CNT);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_l            <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cnt             <= '0;
      pend            <= 1'b0;
      pend_data       <= '0;
      cpu.pal_wait    <= 1'b0;
      cpu.pal_pending <= 1'b0;
    end else begin
      wr_l <= wr;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nxt;
      // a request arriving while an entry is already pending is dropped
      if (req && full && !pend)
        pend_data <= {cpu.cpu_addr, cpu.cpu_dout};
      pend            <= pend_nxt;
      cpu.pal_wait    <= pend_nxt | full_nxt;
      cpu.pal_pending <= pend_nxt | (cnt_nxt != '0);
    end
  end

  // --- FSM: state register and registered outputs -------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      state    <= state_nxt;
      ram_we   <= ram_we_nxt;
      ram_addr <= ram_addr_nxt;
      ram_din  <= ram_din_nxt;
    end
  end

`ifdef JTBUBL_PALCLR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
      clr_busy <= 1'b1;
    end else begin
      if (state == ST_CLEAR)
        clr_addr <= clr_addr + 1'b1;
      clr_busy <= clr_busy_nxt;
    end
  end
`else
  assign clr_busy = 1'b0;
`endif

  // --- FSM: next state ----------------------------------------------------
  // COMMIT means the registered strobe is currently high; popping again in
  // COMMIT keeps back-to-back writes at one byte per clk.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
`ifdef JTBUBL_PALCLR_EN
      ST_CLEAR: if (clr_addr == 9'h1FF) state_nxt = ST_IDLE;
`else
      ST_CLEAR: state_nxt = ST_IDLE;
`endif
      ST_IDLE: begin
        pop = ~empty & blank;
        if (pop)
          state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        pop = ~empty & blank;
        if (!pop)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --- FSM: outputs (next values of the registered RAM port) --------------
  always_comb begin
    ram_we_nxt   = pop;
    ram_addr_nxt = ram_addr;
    ram_din_nxt  = ram_din;
    if (pop)
      {ram_addr_nxt, ram_din_nxt} = mem[rd_ptr];
`ifdef JTBUBL_PALCLR_EN
    clr_busy_nxt = (state == ST_CLEAR);
    if (state == ST_CLEAR) begin
      ram_we_nxt   = 1'b1;
      ram_addr_nxt = clr_addr;
      ram_din_nxt  = '0;
    end
`endif
  end

endmodule

// File: tb/tb_jtbubl_pal_sched.sv
// Bench for jtbubl_pal_sched: queue-level model checked every cycle plus
// directed scenarios with literal expectations. Works with or without
// JTBUBL_PALCLR_EN.
module tb_jtbubl_pal_sched;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef JTBUBL_PALCLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       LHBL = 1'b1;
  logic       LVBL = 1'b1;
  logic       clr_busy, ram_we;
  logic [8:0] ram_addr;
  logic [7:0] ram_din;

  jtbubl_pal_sched_if bus();

  jtbubl_pal_sched #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .cpu      (bus.slave),
    .clr_busy (clr_busy),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (queue level) ----------------
  logic [16:0] mq[$];
  bit          m_pend;
  logic [16:0] m_pdata;
  bit          m_prev_wr;
  bit          m_clearing;
  int          m_cidx;
  bit          e_we, e_wait, e_pending, e_busy;
  logic [8:0]  e_addr;
  logic [7:0]  e_din;
  bit          model_ok = 1'b0;

  bit          m_wr, m_req, m_blank, m_pop, m_was_full, m_had_pend;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_pend = 0; m_prev_wr = 0; m_clearing = CLR_EN; m_cidx = 0;
      e_we = 0; e_addr = '0; e_din = '0; e_wait = 0; e_pending = 0;
      e_busy = CLR_EN;
      model_ok = 1'b1;
    end else begin
      m_wr       = bus.pal_cs & ~bus.cpu_rnw;
      m_req      = m_wr & ~m_prev_wr;
      m_prev_wr  = m_wr;
      m_blank    = !LHBL || !LVBL;
      m_was_full = (mq.size() == DEPTH);
      m_had_pend = m_pend;
      e_busy     = m_clearing;
      m_pop      = 0;
      if (m_clearing) begin
        e_we = 1; e_addr = 9'(m_cidx); e_din = 8'h00;
        m_cidx++;
        if (m_cidx == 512) m_clearing = 0;
      end else begin
        m_pop = m_blank && (mq.size() > 0);
        e_we  = m_pop;
        if (m_pop) {e_addr, e_din} = mq.pop_front();
      end
      if (m_had_pend && m_pop) begin
        mq.push_back(m_pdata);
        m_pend = 0;
      end
      if (m_req) begin
        if (!m_was_full) mq.push_back({bus.cpu_addr, bus.cpu_dout});
        else if (!m_had_pend) begin
          m_pend  = 1;
          m_pdata = {bus.cpu_addr, bus.cpu_dout};
        end
      end
      e_wait    = m_pend || (mq.size() == DEPTH);
      e_pending = m_pend || (mq.size() > 0);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_ram_we",      int'(ram_we),          int'(e_we));
      check("m_ram_addr",    int'(ram_addr),        int'(e_addr));
      check("m_ram_din",     int'(ram_din),         int'(e_din));
      check("m_pal_wait",    int'(bus.pal_wait),    int'(e_wait));
      check("m_pal_pending", int'(bus.pal_pending), int'(e_pending));
      check("m_clr_busy",    int'(clr_busy),        int'(e_busy));
    end
  end

  // ---------------- write log ----------------
  logic [16:0] wlog[$];
  int          wcyc[$];
  int          cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (ram_we) begin
      wlog.push_back({ram_addr, ram_din});
      wcyc.push_back(cyc_cnt);
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(logic [8:0] a, logic [7:0] d);
    bus.pal_cs   = 1'b1;
    bus.cpu_rnw  = 1'b0;
    bus.cpu_addr = a;
    bus.cpu_dout = d;
    step(1);
    bus.pal_cs  = 1'b0;
    bus.cpu_rnw = 1'b1;
    step(1);
  endtask

  task automatic clear_log();
    wlog.delete();
    wcyc.delete();
  endtask

  task automatic wait_clear_done(string name);
    int n = 0;
    while (clr_busy && n < 700) begin
      step(1);
      n++;
    end
    check(name, int'(clr_busy), 0);
  endtask

  initial begin
    int bad;
    bus.pal_cs   = 1'b0;
    bus.cpu_rnw  = 1'b1;
    bus.cpu_addr = '0;
    bus.cpu_dout = '0;

    // reset state
    rst = 1'b1;
    step(3);
    check("rst_ram_we",   int'(ram_we),          0);
    check("rst_ram_addr", int'(ram_addr),        0);
    check("rst_wait",     int'(bus.pal_wait),    0);
    check("rst_pending",  int'(bus.pal_pending), 0);
    check("rst_clr_busy", int'(clr_busy),        int'(CLR_EN));
    rst = 1'b0;

`ifdef JTBUBL_PALCLR_EN
    wait_clear_done("clear_done");
    check("clear_count", wlog.size(), 512);
    bad = 0;
    foreach (wlog[i]) if (wlog[i] != {9'(i), 8'h00}) bad++;
    check("clear_pattern_errors", bad, 0);
`else
    step(4);
    check("noclr_busy",   int'(clr_busy), 0);
    check("noclr_writes", wlog.size(),    0);
`endif
    clear_log();

    // single write in active video, committed on LHBL low
    cpu_write(9'h0A3, 8'h5C);
    step(2);
    check("single_pending", int'(bus.pal_pending), 1);
    check("single_nowrite", wlog.size(), 0);
    LHBL = 1'b0;
    step(1);
    check("single_we",   int'(ram_we),   1);
    check("single_addr", int'(ram_addr), 'h0A3);
    check("single_din",  int'(ram_din),  'h5C);
    LHBL = 1'b1;
    step(1);
    check("single_we_off",  int'(ram_we),          0);
    check("single_drained", int'(bus.pal_pending), 0);
    clear_log();

    // five writes: fifth overflows into pending
    for (int i = 0; i < 5; i++) cpu_write(9'h100 + 9'(i), 8'h10 + 8'(i));
    check("five_wait", int'(bus.pal_wait), 1);
    check("five_nowrite", wlog.size(), 0);
    LVBL = 1'b0;
    step(6);
    LVBL = 1'b1;
    step(1);
    check("five_count", wlog.size(), 5);
    bad = 0;
    foreach (wlog[i]) if (wlog[i] != {9'h100 + 9'(i), 8'h10 + 8'(i)}) bad++;
    check("five_order_errors", bad, 0);
    check("five_consecutive", (wcyc.size() == 5) ? (wcyc[4] - wcyc[0]) : -1, 4);
    check("five_wait_clear", int'(bus.pal_wait), 0);
    clear_log();

    // request held for 10 clks
    bus.pal_cs   = 1'b1;
    bus.cpu_rnw  = 1'b0;
    bus.cpu_addr = 9'h1FF;
    bus.cpu_dout = 8'hA5;
    step(10);
    bus.pal_cs  = 1'b0;
    bus.cpu_rnw = 1'b1;
    step(1);
    check("held_pending", int'(bus.pal_pending), 1);
    LHBL = 1'b0;
    step(4);
    LHBL = 1'b1;
    step(1);
    check("held_count", wlog.size(), 1);
    check("held_entry", (wlog.size() > 0) ? int'(wlog[0]) : -1, int'({9'h1FF, 8'hA5}));
    clear_log();

    // short blank window: 2 of 4 entries committed
    for (int i = 0; i < 4; i++) cpu_write(9'h020 + 9'(i), 8'h80 + 8'(i));
    LHBL = 1'b0;
    step(2);
    LHBL = 1'b1;
    step(3);
    check("window_count",   wlog.size(), 2);
    check("window_second",  (wlog.size() > 1) ? int'(wlog[1]) : -1, int'({9'h021, 8'h81}));
    check("window_pending", int'(bus.pal_pending), 1);
    LHBL = 1'b0;
    step(3);
    LHBL = 1'b1;
    step(1);
    check("window_rest", wlog.size(), 4);
    check("window_last", (wlog.size() > 3) ? int'(wlog[3]) : -1, int'({9'h023, 8'h83}));
    clear_log();

    // reset during a commit burst
    for (int i = 0; i < 3; i++) cpu_write(9'h0C0 + 9'(i), 8'hE0 + 8'(i));
    LHBL = 1'b0;
    step(1);
    check("burst_we", int'(ram_we), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    bad = 0;
    for (int i = 1; i < wlog.size(); i++) if (wlog[i][7:0] != 8'h00) bad++;
    check("rst_no_commit", bad, 0);
    check("rst_mid_pending", int'(bus.pal_pending), 0);
`ifdef JTBUBL_PALCLR_EN
    check("rst_clr_restart", (wlog.size() > 1) ? int'(wlog[1][16:8]) : -1, 0);
    wait_clear_done("rst_clear_done");
`else
    check("rst_idle_writes", wlog.size(), 1);
`endif
    LHBL = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end
endmodule
